// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline stages: state encoding and the
// helpers that map a stage state onto its handshake and occupancy outputs.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int unsigned PIPE_OCC_W = 2;

    function automatic logic [PIPE_OCC_W-1:0] occ_of(input pipe_state_e s);
        logic [PIPE_OCC_W-1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            TWO:     occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

    // A stage can take a new entry whenever the skid slot is still free.
    function automatic logic can_accept(input pipe_state_e s);
        return (s != TWO);
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload+control holding register with load enable; cleared by the
// asynchronous active-low reset so no partial entry survives a reset.
module pipe_entry #(
    parameter int unsigned W = 39
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Entry storage: loads only when the owning stage decides to.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            entry_q <= {W{1'b0}};
        end else if (load_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Two-entry skid-buffered pipeline stage: in_ready_o is registered so the
// upstream handshake never sees a combinational path from out_ready_i.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 7
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [CTRL_W-1:0] in_ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [CTRL_W-1:0] out_ctrl_o,
    output logic [1:0]        occupancy_o
);

    localparam int unsigned ENT_W = DATA_W + CTRL_W;

    pipe_state_e      state_q;
    pipe_state_e      state_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       occ_q;

    logic             in_xfer_s;
    logic             out_xfer_s;
    logic             main_load_s;
    logic             skid_load_s;
    logic             main_from_skid_s;
    logic [ENT_W-1:0] in_ent_s;
    logic [ENT_W-1:0] main_d;
    logic [ENT_W-1:0] main_q;
    logic [ENT_W-1:0] skid_q;

    assign in_ent_s   = {in_data_i, in_ctrl_i};
    assign in_xfer_s  = in_valid_i & in_ready_q;
    assign out_xfer_s = out_valid_q & out_ready_i;

    // Next state and entry load decisions; flush overrides every transfer.
    always_comb begin
        state_d          = state_q;
        main_load_s      = 1'b0;
        skid_load_s      = 1'b0;
        main_from_skid_s = 1'b0;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_xfer_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                    end else begin
                        state_d     = EMPTY;
                    end
                end
                ONE: begin
                    if (in_xfer_s && out_xfer_s) begin
                        main_load_s = 1'b1;
                        state_d     = ONE;
                    end else if (in_xfer_s) begin
                        skid_load_s = 1'b1;
                        state_d     = TWO;
                    end else if (out_xfer_s) begin
                        state_d     = EMPTY;
                    end else begin
                        state_d     = ONE;
                    end
                end
                TWO: begin
                    // in_ready_o is low here, so only the drain can happen.
                    if (out_xfer_s) begin
                        main_load_s      = 1'b1;
                        main_from_skid_s = 1'b1;
                        state_d          = ONE;
                    end else begin
                        state_d          = TWO;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign main_d = main_from_skid_s ? skid_q : in_ent_s;

    // State register with the handshake/occupancy outputs registered alongside.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= can_accept(state_d);
            out_valid_q <= (state_d != EMPTY);
            occ_q       <= occ_of(state_d);
        end
    end

    pipe_entry #(
        .W (ENT_W)
    ) u_main (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (main_load_s),
        .d_i    (main_d),
        .q_o    (main_q)
    );

    pipe_entry #(
        .W (ENT_W)
    ) u_skid (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (skid_load_s),
        .d_i    (in_ent_s),
        .q_o    (skid_q)
    );

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign occupancy_o = occ_q;
    assign out_data_o  = main_q[ENT_W-1:CTRL_W];
    // Bubbles present NOP control so downstream decode never sees stale bits.
    assign out_ctrl_o  = out_valid_q ? main_q[CTRL_W-1:0] : {CTRL_W{1'b0}};

endmodule
